// File: rtl/execute_mem_cmtq.sv
// Commit-delay queue behind the memory-execute output flops: holds each result
// until its commit delay expires, then hands it to ROB writeback in order.
module execute_mem_cmtq #(
    parameter int DEPTH        = 4,
    parameter int STALL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_flush,
    input  logic        i_valid,
    input  logic [3:0]  i_dst_rob,
    input  logic [7:0]  i_fid,
    input  logic [31:0] i_result,
    input  logic [3:0]  i_cmtdelay,
    input  logic        i_lsmiss,
    output logic        o_stall,
    output logic        o_overflow,
    output logic        o_wb_valid,
    input  logic        i_wb_ready,
    output logic [3:0]  o_wb_dst_rob,
    output logic [7:0]  o_wb_fid,
    output logic [31:0] o_wb_result,
    output logic        o_wb_lsmiss
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - STALL_MARGIN);

    logic [3:0]  dst_rob_q [DEPTH];
    logic [7:0]  fid_q     [DEPTH];
    logic [31:0] result_q  [DEPTH];
    logic        lsmiss_q  [DEPTH];
    logic [3:0]  delay_q   [DEPTH];
    logic        valid_q   [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count, count_next;
    logic             stall_q, overflow_q;
    logic             full, push_req, push, pop;

    assign full     = (count == FULL_CNT);
    assign push_req = i_valid && !i_flush;
    assign pop      = o_wb_valid && i_wb_ready && !i_flush;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                dst_rob_q[i] <= '0;
                fid_q[i]     <= '0;
                result_q[i]  <= '0;
                lsmiss_q[i]  <= 1'b0;
                delay_q[i]   <= '0;
                valid_q[i]   <= 1'b0;
            end
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
            end
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            stall_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && delay_q[i] != 4'd0) begin
                    delay_q[i] <= delay_q[i] - 4'd1;
                end
            end
            if (pop) begin
                valid_q[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            // Placed after the pop so a full-queue push into the freed slot wins.
            if (push) begin
                dst_rob_q[tail] <= i_dst_rob;
                fid_q[tail]     <= i_fid;
                result_q[tail]  <= i_result;
                lsmiss_q[tail]  <= i_lsmiss;
                delay_q[tail]   <= i_cmtdelay;
                valid_q[tail]   <= 1'b1;
                tail            <= tail + PTR_W'(1);
            end
            if (push_req && !push) begin
                overflow_q <= 1'b1;
            end
            count   <= count_next;
            stall_q <= (count_next >= STALL_CNT);
        end
    end

    assign o_wb_valid   = valid_q[head] && (delay_q[head] == 4'd0);
    assign o_wb_dst_rob = dst_rob_q[head];
    assign o_wb_fid     = fid_q[head];
    assign o_wb_result  = result_q[head];
    assign o_wb_lsmiss  = lsmiss_q[head];
    assign o_stall      = stall_q;
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_execute_mem_cmtq.sv
// Directed bench for execute_mem_cmtq: vector table of per-cycle stimulus and
// expected post-edge outputs, plus hand-written reset sequences.
module tb_execute_mem_cmtq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_flush, i_valid, i_lsmiss, i_wb_ready;
    logic [3:0]  i_dst_rob, i_cmtdelay;
    logic [7:0]  i_fid;
    logic [31:0] i_result;
    logic        o_stall, o_overflow, o_wb_valid, o_wb_lsmiss;
    logic [3:0]  o_wb_dst_rob;
    logic [7:0]  o_wb_fid;
    logic [31:0] o_wb_result;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        valid, flush, ready;
        logic [3:0]  dst;
        logic [7:0]  fid;
        logic [31:0] res;
        logic [3:0]  dly;
        logic        lsm;
        logic        ev, es, eo;
        logic [3:0]  edst;
        logic [7:0]  efid;
        logic [31:0] eres;
        logic        elsm;
    } vec_t;

    vec_t vecs[$];

    execute_mem_cmtq #(.DEPTH(4), .STALL_MARGIN(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_flush      (i_flush),
        .i_valid      (i_valid),
        .i_dst_rob    (i_dst_rob),
        .i_fid        (i_fid),
        .i_result     (i_result),
        .i_cmtdelay   (i_cmtdelay),
        .i_lsmiss     (i_lsmiss),
        .o_stall      (o_stall),
        .o_overflow   (o_overflow),
        .o_wb_valid   (o_wb_valid),
        .i_wb_ready   (i_wb_ready),
        .o_wb_dst_rob (o_wb_dst_rob),
        .o_wb_fid     (o_wb_fid),
        .o_wb_result  (o_wb_result),
        .o_wb_lsmiss  (o_wb_lsmiss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
        end
    endtask

    task automatic addVec(input logic v, fl, rdy, input logic [3:0] dst, input logic [7:0] fid,
                          input logic [31:0] res, input logic [3:0] dly, input logic lsm,
                          input logic ev, es, eo, input logic [3:0] edst, input logic [7:0] efid,
                          input logic [31:0] eres, input logic elsm);
        vec_t t;
        t.valid = v;   t.flush = fl;  t.ready = rdy;
        t.dst = dst;   t.fid = fid;   t.res = res;   t.dly = dly;  t.lsm = lsm;
        t.ev = ev;     t.es = es;     t.eo = eo;
        t.edst = edst; t.efid = efid; t.eres = eres; t.elsm = elsm;
        vecs.push_back(t);
    endtask

    task automatic addIdle(input logic rdy, input logic ev, es, eo, input logic [3:0] edst,
                           input logic [7:0] efid, input logic [31:0] eres, input logic elsm);
        addVec(1'b0, 1'b0, rdy, 4'h0, 8'h00, 32'h0, 4'h0, 1'b0, ev, es, eo, edst, efid, eres, elsm);
    endtask

    task automatic applyStimulus(input vec_t t);
        i_valid    = t.valid;
        i_flush    = t.flush;
        i_wb_ready = t.ready;
        i_dst_rob  = t.dst;
        i_fid      = t.fid;
        i_result   = t.res;
        i_cmtdelay = t.dly;
        i_lsmiss   = t.lsm;
    endtask

    task automatic checkOutput(input vec_t t, input int row);
        chk("wb_valid", row, 32'(o_wb_valid), 32'(t.ev));
        chk("stall", row, 32'(o_stall), 32'(t.es));
        chk("overflow", row, 32'(o_overflow), 32'(t.eo));
        if (t.ev) begin
            chk("wb_dst_rob", row, 32'(o_wb_dst_rob), 32'(t.edst));
            chk("wb_fid", row, 32'(o_wb_fid), 32'(t.efid));
            chk("wb_result", row, o_wb_result, t.eres);
            chk("wb_lsmiss", row, 32'(o_wb_lsmiss), 32'(t.elsm));
        end
    endtask

    task automatic checkResetState(input int row);
        chk("rst_wb_valid", row, 32'(o_wb_valid), 32'd0);
        chk("rst_stall", row, 32'(o_stall), 32'd0);
        chk("rst_overflow", row, 32'(o_overflow), 32'd0);
        chk("rst_dst_rob", row, 32'(o_wb_dst_rob), 32'd0);
        chk("rst_fid", row, 32'(o_wb_fid), 32'd0);
        chk("rst_result", row, o_wb_result, 32'd0);
        chk("rst_lsmiss", row, 32'(o_wb_lsmiss), 32'd0);
    endtask

    task automatic runVectors(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput(vecs[i], i);
        end
    endtask

    task automatic driveIdle();
        i_valid = 1'b0; i_flush = 1'b0; i_wb_ready = 1'b0;
        i_dst_rob = '0; i_fid = '0; i_result = '0; i_cmtdelay = '0; i_lsmiss = 1'b0;
    endtask

    initial begin
        int n_a, n_b, n_c;

        // Single entry with no delay, then a delay-3 entry
        addVec(1,0,1, 4'h3, 8'h12, 32'hDEADBEEF, 4'd0, 0,  1,0,0, 4'h3, 8'h12, 32'hDEADBEEF, 0);
        addIdle(1, 0,0,0, 0,0,0,0);
        addVec(1,0,1, 4'h5, 8'h21, 32'h11111111, 4'd3, 1,  0,0,0, 0,0,0,0);
        addIdle(1, 0,0,0, 0,0,0,0);
        addIdle(1, 0,0,0, 0,0,0,0);
        addIdle(1, 1,0,0, 4'h5, 8'h21, 32'h11111111, 1);
        addIdle(1, 0,0,0, 0,0,0,0);
        // In-order: slow A ahead of ready B
        addVec(1,0,1, 4'h1, 8'hA0, 32'hAAAA0000, 4'd5, 0,  0,0,0, 0,0,0,0);
        addVec(1,0,1, 4'h2, 8'hB0, 32'hBBBB0000, 4'd0, 1,  0,1,0, 0,0,0,0);
        addIdle(1, 0,1,0, 0,0,0,0);
        addIdle(1, 0,1,0, 0,0,0,0);
        addIdle(1, 0,1,0, 0,0,0,0);
        addIdle(1, 1,1,0, 4'h1, 8'hA0, 32'hAAAA0000, 0);
        addIdle(1, 1,0,0, 4'h2, 8'hB0, 32'hBBBB0000, 1);
        addIdle(1, 0,0,0, 0,0,0,0);
        // Backpressure, fill, overflow, drain
        addVec(1,0,0, 4'h4, 8'h31, 32'h10, 4'd0, 0,  1,0,0, 4'h4, 8'h31, 32'h10, 0);
        addVec(1,0,0, 4'h6, 8'h32, 32'h20, 4'd1, 1,  1,1,0, 4'h4, 8'h31, 32'h10, 0);
        addVec(1,0,0, 4'h7, 8'h33, 32'h30, 4'd0, 0,  1,1,0, 4'h4, 8'h31, 32'h10, 0);
        addVec(1,0,0, 4'h8, 8'h34, 32'h40, 4'd2, 1,  1,1,0, 4'h4, 8'h31, 32'h10, 0);
        addVec(1,0,0, 4'h9, 8'h35, 32'h50, 4'd0, 0,  1,1,1, 4'h4, 8'h31, 32'h10, 0);
        addIdle(1, 1,1,1, 4'h6, 8'h32, 32'h20, 1);
        addIdle(1, 1,1,1, 4'h7, 8'h33, 32'h30, 0);
        addIdle(1, 1,0,1, 4'h8, 8'h34, 32'h40, 1);
        addIdle(1, 0,0,1, 0,0,0,0);
        n_a = vecs.size();

        // Full queue with simultaneous push and pop, wrap-around drain
        addVec(1,0,0, 4'h1, 8'h41, 32'h100, 4'd0, 0,  1,0,0, 4'h1, 8'h41, 32'h100, 0);
        addVec(1,0,0, 4'h2, 8'h42, 32'h200, 4'd0, 0,  1,1,0, 4'h1, 8'h41, 32'h100, 0);
        addVec(1,0,0, 4'h3, 8'h43, 32'h300, 4'd0, 0,  1,1,0, 4'h1, 8'h41, 32'h100, 0);
        addVec(1,0,0, 4'h4, 8'h44, 32'h400, 4'd0, 0,  1,1,0, 4'h1, 8'h41, 32'h100, 0);
        addVec(1,0,1, 4'h5, 8'h45, 32'h500, 4'd0, 1,  1,1,0, 4'h2, 8'h42, 32'h200, 0);
        addIdle(1, 1,1,0, 4'h3, 8'h43, 32'h300, 0);
        addIdle(1, 1,1,0, 4'h4, 8'h44, 32'h400, 0);
        addIdle(1, 1,0,0, 4'h5, 8'h45, 32'h500, 1);
        addIdle(1, 0,0,0, 0,0,0,0);
        // Flush with a same-cycle push and pop
        addVec(1,0,0, 4'hC, 8'h61, 32'h600, 4'd0, 0,  1,0,0, 4'hC, 8'h61, 32'h600, 0);
        addVec(1,0,0, 4'hD, 8'h62, 32'h700, 4'd0, 0,  1,1,0, 4'hC, 8'h61, 32'h600, 0);
        addVec(1,0,0, 4'hE, 8'h63, 32'h800, 4'd0, 0,  1,1,0, 4'hC, 8'h61, 32'h600, 0);
        addVec(1,1,1, 4'hF, 8'h64, 32'h900, 4'd0, 0,  0,0,0, 0,0,0,0);
        addIdle(1, 0,0,0, 0,0,0,0);
        addVec(1,0,0, 4'hA, 8'h65, 32'hA00, 4'd0, 1,  1,0,0, 4'hA, 8'h65, 32'hA00, 1);
        addIdle(1, 0,0,0, 0,0,0,0);
        n_b = vecs.size();

        // Refill to overflow ahead of the asynchronous reset
        addVec(1,0,0, 4'h1, 8'h71, 32'h1000, 4'd2, 0,  0,0,0, 0,0,0,0);
        addVec(1,0,0, 4'h2, 8'h72, 32'h2000, 4'd0, 0,  0,1,0, 0,0,0,0);
        addVec(1,0,0, 4'h3, 8'h73, 32'h3000, 4'd0, 0,  1,1,0, 4'h1, 8'h71, 32'h1000, 0);
        addVec(1,0,0, 4'h4, 8'h74, 32'h4000, 4'd0, 0,  1,1,0, 4'h1, 8'h71, 32'h1000, 0);
        addVec(1,0,0, 4'h5, 8'h75, 32'h5000, 4'd0, 0,  1,1,1, 4'h1, 8'h71, 32'h1000, 0);
        n_c = vecs.size();

        driveIdle();
        resetn = 1'b0;
        #2;
        checkResetState(-1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        runVectors(0, n_a);

        // Clear the sticky overflow between phases
        resetn = 1'b0;
        #1;
        checkResetState(-2);
        #2;
        resetn = 1'b1;
        runVectors(n_a, n_b);
        runVectors(n_b, n_c);

        // Asynchronous reset between edges with a push pending
        i_valid = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        checkResetState(-3);
        driveIdle();
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_wb_valid", -4, 32'(o_wb_valid), 32'd0);
        chk("post_rst_stall", -4, 32'(o_stall), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
